// File: rtl/regfile_mp_if.sv
// Bundle of read, writeback and scoreboard signals between decode/writeback and regfile_mp.
// Parameters must match the regfile_mp instance that the bundle connects to.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rs_raddr;
    logic [NRD*XLEN-1:0] rs_rdata;
    logic [NRD-1:0]      rs_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic                sb_flush;
    logic [NREG-1:0]     busy_vec;

    modport master (
        output rs_raddr, wr_en, wr_addr, wr_data, sb_set, sb_addr, sb_flush,
        input  rs_rdata, rs_busy, busy_vec
    );

    modport slave (
        input  rs_raddr, wr_en, wr_addr, wr_data, sb_set, sb_addr, sb_flush,
        output rs_rdata, rs_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and a per-register busy scoreboard.
// x0 is hardwired to zero; the highest-index enabled write port wins on an address conflict.

// One combinational read port: reset/x0 force zero, then bypass, then storage.
module regfile_mp_rdport #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    parameter int AW     = 5
) (
    input  logic                       rstn,
    input  logic [AW-1:0]              raddr,
    input  logic [NREG-1:0][XLEN-1:0]  mem,
    input  logic [NREG-1:0]            busy,
    input  logic [NREG-1:0]            reg_we,
    input  logic [NREG-1:0][XLEN-1:0]  reg_wd,
    output logic [XLEN-1:0]            rdata,
    output logic                       rbusy
);
    logic hit;

    assign hit = (BYPASS != 0) && reg_we[raddr];

    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (rstn && raddr != '0) begin
            if (hit) begin
                rdata = reg_wd[raddr];
            end else begin
                rdata = mem[raddr];
                rbusy = busy[raddr];
            end
        end
    end
endmodule

module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rstn,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][XLEN-1:0] mem;
    logic [NREG-1:0]           busy_q;
    logic [NREG-1:0]           busy_nxt;
    logic [NWR-1:0][AW-1:0]    wa;
    logic [NWR-1:0][XLEN-1:0]  wd;
    logic [NREG-1:0]           reg_we;
    logic [NREG-1:0][XLEN-1:0] reg_wd;
    logic [NRD-1:0][XLEN-1:0]  rd_data;
    logic [NRD-1:0]            rd_busy;

    assign wa = bus.wr_addr;
    assign wd = bus.wr_data;

    // Per-register winning write: later (higher-index) ports overwrite earlier ones.
    always_comb begin
        reg_we = '0;
        reg_wd = '0;
        for (int p = 0; p < NWR; p++) begin
            if (bus.wr_en[p]) begin
                reg_we[wa[p]] = 1'b1;
                reg_wd[wa[p]] = wd[p];
            end
        end
        reg_we[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (reg_we[r]) mem[r] <= reg_wd[r];
            end
        end
    end

    // A new producer (sb_set) outranks the retirement of the old one to the same register.
    always_comb begin
        busy_nxt = busy_q;
        if (bus.sb_flush) begin
            busy_nxt = '0;
        end else begin
            busy_nxt = busy_q & ~reg_we;
            if (bus.sb_set) busy_nxt[bus.sb_addr] = 1'b1;
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) busy_q <= '0;
        else       busy_q <= busy_nxt;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_mp_rdport #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_rd (
            .rstn   (rstn),
            .raddr  (bus.rs_raddr[k*AW +: AW]),
            .mem    (mem),
            .busy   (busy_q),
            .reg_we (reg_we),
            .reg_wd (reg_wd),
            .rdata  (rd_data[k]),
            .rbusy  (rd_busy[k])
        );
    end

    assign bus.rs_rdata = rd_data;
    assign bus.rs_busy  = rd_busy;
    assign bus.busy_vec = busy_q;
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the core, with same-cycle write-to-read bypass and a per-register busy scoreboard. It sits between decode, which reads operands and marks destinations busy, and the writeback stages, which write results. Width, depth, read-port count and write-port count are all configurable. Up to NWR results can retire per cycle, and decode can detect operands still pending from long-latency operations.

## Interface
- XLEN, 32, data width of each register
- NREG, 32, number of registers (power of two, ≥2); AW = $clog2(NREG)
- NRD, 2, number of read ports (≥1)
- NWR, 2, number of write ports (≥1)
- BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored value only
- clk  in  1  core clock; all state updates on rising edge
- rstn  in  1  reset: asynchronous, active-low
- rs_raddr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rs_rdata  out  NRD*XLEN  read data, combinational, per port
- rs_busy  out  NRD  1 = operand of port k is still pending
- wr_en  in  NWR  write enable per write port
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- sb_set  in  1  mark sb_addr busy at the next edge (long-latency op issued)
- sb_addr  in  AW  register to mark busy
- sb_flush  in  1  clear every busy bit at the next edge (pipeline flush)
- busy_vec  out  NREG  registered scoreboard, bit i = register i busy

## Operation
- Register 0 is hardwired to zero. Writes to it are discarded, sb_set to it is ignored, busy_vec[0] is always 0, and reads of it return 0 with rs_busy = 0.
- Write resolution: for each register, the enabled write port with the highest index that targets it wins. Lower-index ports targeting the same register are dropped. Writes to different registers in the same cycle all commit.
- Read port k, in priority order:
  - rstn low: data 0, busy 0.
  - raddr == 0: data 0, busy 0.
  - BYPASS = 1 and any enabled write targets raddr: data is the winning write's data (highest index), busy 0.
  - Otherwise: data is the stored value, busy is busy_vec[raddr].
- Scoreboard update at each rising edge, highest priority first:
  - sb_flush = 1: all bits cleared. A concurrent sb_set is ignored.
  - Otherwise, each enabled write to register r (r ≠ 0) clears bit r.
  - Then sb_set with sb_addr ≠ 0 sets bit sb_addr. Set overrides a clear of the same register in the same cycle, because the new producer was issued after the old result returned.
- Writes commit regardless of busy state. The scoreboard is advisory only.
- With BYPASS = 0, a read of a register being written in the same cycle returns the old value. rs_busy follows busy_vec, with no bypass clearing.

## Timing
- Reset (rstn low, asynchronous): all registers = 0, busy_vec = 0, rs_rdata = 0, rs_busy = 0 immediately. These hold while rstn is low. Writes and sb_set are ignored during reset.
- Deassertion is sampled by clk. The first edge with rstn high performs normal updates.
- Read latency is 0 cycles (combinational from rs_raddr, wr_*, state).
- Write latency is 1 edge. Stored data is visible through the non-bypass path from the next cycle.
- Scoreboard latency is 1 edge. busy_vec reflects sb_set from the next cycle. rs_busy for the same-cycle sb_set address is still the old value.
- Reset asserted mid-operation: all state clears immediately. Pending writes on that edge are lost.
- There are no combinational paths from rs_raddr to any state element.

## Test plan
- Reset: hold rstn low with wr_en = 2'b11 and writes to x5/x6 → all rs_rdata = 0 and busy_vec = 0. After release, reading x5 returns 0.
- Write/read: port 0 writes x3 = 0xDEADBEEF → same cycle rs_rdata(port 1, x3) = 0xDEADBEEF (BYPASS = 1). The next cycle returns the same value from storage. With BYPASS = 0, the same-cycle read returns 0.
- Write conflict: port 0 writes x7 = 0x11 and port 1 writes x7 = 0x22 in the same cycle → x7 = 0x22 afterward. Same-cycle bypass also gives 0x22.
- x0: write x0 = 0xFFFFFFFF and set sb_addr = 0 → reading x0 gives 0, busy_vec[0] = 0, rs_busy = 0.
- Scoreboard:
  - sb_set x9 → next cycle busy_vec[9] = 1, rs_busy = 1 for a read of x9.
  - Write x9 = 0x55 → same cycle rs_busy = 0, data 0x55. busy_vec[9] = 0 next cycle.
  - sb_set x9 together with a write to x9 → busy_vec[9] = 1.
- Flush: set x4, x8, x12 busy, then pulse sb_flush with sb_set x10 → busy_vec = 0 next cycle. Register contents are unchanged.
